// File: rtl/demux_router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : demux_router_pkg                                        |
// | Brief    : Shared types and default parameters for demux_router.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package demux_router_pkg;

  // Up to eight output channels, so three bits index any channel.
  typedef logic [2:0] ch_idx_t;

  localparam int C_DEFAULT_CH = 0;
  localparam int C_DEPTH      = 2;

endpackage : demux_router_pkg
`default_nettype wire

// File: rtl/demux_router_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : demux_router_fifo                                       |
// | Brief    : Per-channel FIFO; head word exposed with zero when      |
// |            empty, pop on valid && ready, no push-to-pop bypass.    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module demux_router_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop_ready,
  output logic                  o_full,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  // Status comes from the registered count only, so a word written this
  // cycle is never visible (or poppable) until the next one.
  assign o_full  = (r_count == C_FULL_CNT);
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = o_valid && i_pop_ready;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : demux_router_fifo
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : demux_router                                            |
// | Brief    : Routes one input stream to NUM_CH buffered outputs by   |
// |            select; out-of-range selects go to DEFAULT_CH and pulse |
// |            sel_err.                                                |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module demux_router
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int SEL_BITS   = 2,
  parameter int DEPTH      = C_DEPTH,
  parameter int DEFAULT_CH = C_DEFAULT_CH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_BITS-1:0]          in_sel,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         sel_err
);

  // One extra bit so NUM_CH == 2**SEL_BITS still compares correctly.
  localparam logic [SEL_BITS:0] C_NUM_CH = (SEL_BITS + 1)'(NUM_CH);

  logic              w_sel_oor;
  ch_idx_t           w_eff_ch;
  logic              w_accept;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push;
  logic              r_sel_err;

  assign w_sel_oor = ({1'b0, in_sel} >= C_NUM_CH);
  assign w_eff_ch  = w_sel_oor ? ch_idx_t'(DEFAULT_CH) : ch_idx_t'(in_sel);
  assign w_accept  = in_valid && in_ready;
  assign sel_err   = r_sel_err;

  // Ready reflects only the addressed channel's registered fullness.
  always_comb begin
    in_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_eff_ch == ch_idx_t'(i)) in_ready = ~w_full[i];
    end
  end

  // One-cycle error pulse for accepted words whose select was out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sel_err <= 1'b0;
    else     r_sel_err <= w_accept && w_sel_oor;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_push[gi] = w_accept && (w_eff_ch == ch_idx_t'(gi));

      demux_router_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push[gi]),
        .i_data      (in_data),
        .i_pop_ready (out_ready[gi]),
        .o_full      (w_full[gi]),
        .o_valid     (out_valid[gi]),
        .o_data      (out_data[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule : demux_router
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_demux_router                                         |
// | Brief    : Self-checking bench for demux_router against a queue    |
// |            model of the routing rules.                             |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_demux_router;

  localparam int DW     = 8;
  localparam int NCH    = 3;
  localparam int SB     = 2;
  localparam int DEP    = 2;
  localparam int DEF_CH = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SB-1:0]   in_sel = '0;
  logic [DW-1:0]   in_data = '0;
  logic [NCH-1:0]  out_valid;
  logic [NCH-1:0]  out_ready = '0;
  logic [NCH*DW-1:0] out_data;
  logic            sel_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue of words per channel plus the expected pulse.
  logic [DW-1:0] q [NCH][$];
  logic          exp_sel_err = 1'b0;

  demux_router #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .SEL_BITS   (SB),
    .DEPTH      (DEP),
    .DEFAULT_CH (DEF_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) q[c].delete();
    exp_sel_err = 1'b0;
  endtask

  // Compare every output against the model's current state.
  task automatic check_outputs(input logic exp_ready);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("out_valid[%0d]", c), 32'(out_valid[c]), 32'(q[c].size() > 0));
      chk($sformatf("out_data[%0d]", c), 32'(out_data[c*DW +: DW]),
          (q[c].size() > 0) ? 32'(q[c][0]) : 32'd0);
    end
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("sel_err", 32'(sel_err), 32'(exp_sel_err));
  endtask

  // One clock cycle: drive, check settled outputs, then advance the model.
  task automatic step(input logic v, input logic [SB-1:0] s, input logic [DW-1:0] d,
                      input logic [NCH-1:0] ordy);
    int   eff;
    logic rdy;
    logic acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    #2;
    eff = (int'(s) < NCH) ? int'(s) : DEF_CH;
    rdy = (q[eff].size() < DEP);
    check_outputs(rdy);
    acc = v && rdy;
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (q[c].size() > 0 && ordy[c]) void'(q[c].pop_front());
    end
    if (acc) q[eff].push_back(d);
    exp_sel_err = acc && (int'(s) >= NCH);
    #1;
  endtask

  initial begin
    // Reset state while rst is held.
    #3;
    check_outputs(1'b1);
    #9;
    rst = 1'b0;

    // Single push to channel 1, consumers stalled.
    step(1'b1, 2'd1, 8'hA5, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b000);
    chk("ch1_head", 32'(out_data[DW +: DW]), 32'hA5);
    step(1'b0, 2'd0, 8'h00, 3'b010);

    // Fill channel 2, observe back-pressure on it only, then drain in order.
    step(1'b1, 2'd2, 8'h11, 3'b000);
    step(1'b1, 2'd2, 8'h22, 3'b000);
    step(1'b0, 2'd2, 8'h00, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b100);
    step(1'b0, 2'd0, 8'h00, 3'b100);
    step(1'b0, 2'd0, 8'h00, 3'b100);

    // Out-of-range select goes to the default channel with a one-cycle pulse.
    step(1'b1, 2'd3, 8'h3C, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b001);
    step(1'b0, 2'd0, 8'h00, 3'b000);

    // Full channel 0: a same-cycle pop does not make room.
    step(1'b1, 2'd0, 8'h01, 3'b000);
    step(1'b1, 2'd0, 8'h02, 3'b000);
    step(1'b1, 2'd0, 8'h03, 3'b001);
    step(1'b1, 2'd0, 8'h03, 3'b001);
    step(1'b0, 2'd0, 8'h00, 3'b001);
    step(1'b0, 2'd0, 8'h00, 3'b001);
    step(1'b0, 2'd0, 8'h00, 3'b001);

    // Full-rate alternating stream with all consumers ready.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, SB'(i % 2), DW'(8'h40 + i), 3'b111);
    end
    step(1'b0, 2'd0, 8'h00, 3'b111);
    step(1'b0, 2'd0, 8'h00, 3'b111);

    // Fill two channels, then reset asynchronously mid-cycle.
    step(1'b1, 2'd1, 8'h71, 3'b000);
    step(1'b1, 2'd2, 8'h72, 3'b000);
    step(1'b1, 2'd1, 8'h73, 3'b000);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs(1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step(1'b1, 2'd2, 8'h99, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b000);
    chk("post_rst_ch2", 32'(out_data[2*DW +: DW]), 32'h99);
    chk("post_rst_ch1_empty", 32'(out_valid[1]), 32'd0);
    step(1'b0, 2'd0, 8'h00, 3'b111);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), SB'($urandom_range(0, 3)),
           DW'($urandom), NCH'($urandom));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_router
`default_nettype wire

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 3: output channel count, range 2..8.
REQ-003 The block SHALL have parameter SEL_BITS, default 2: select width; 2**SEL_BITS >= NUM_CH.
REQ-004 The block SHALL have parameter DEPTH, default 2: per-channel FIFO depth; power of two, >= 2.
REQ-005 The block SHALL have parameter DEFAULT_CH, default 0: channel used for out-of-range selects.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 The block SHALL have port in_valid, input, 1: upstream word present.
REQ-009 The block SHALL have port in_ready, output, 1: block accepts the word this cycle.
REQ-010 The block SHALL have port in_sel, input, SEL_BITS: destination channel.
REQ-011 The block SHALL have port in_data, input, DATA_WIDTH: payload.
REQ-012 The block SHALL have port out_valid, output, NUM_CH: per-channel head-valid.
REQ-013 The block SHALL have port out_ready, input, NUM_CH: per-channel consumer ready.
REQ-014 The block SHALL have port out_data, output, NUM_CH x DATA_WIDTH packed with channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]: per-channel head word.
REQ-015 The block SHALL have port sel_err, output, 1: one-cycle pulse on acceptance of an out-of-range select.

Function
REQ-016 The effective channel SHALL be in_sel when in_sel < NUM_CH, else DEFAULT_CH.
REQ-017 in_ready SHALL be combinational and high iff the effective channel's FIFO is not full, judged on registered count only; a same-cycle pop SHALL NOT make room.
REQ-018 A push SHALL occur iff in_valid && in_ready; the word SHALL be written only to the effective channel's FIFO.
REQ-019 A pop on channel i SHALL occur iff out_valid[i] && out_ready[i]; channels SHALL pop independently and concurrently.
REQ-020 out_valid[i] SHALL be high iff FIFO i count > 0; out_data for channel i SHALL be the head word when valid and all-zero when empty.
REQ-021 Latency SHALL be one cycle: a word pushed in cycle N SHALL appear at out_valid/out_data in cycle N+1 when its FIFO was empty.
REQ-022 Each FIFO SHALL preserve order; read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 Simultaneous push and pop on the same non-full, non-empty channel SHALL leave count unchanged and advance both pointers.
REQ-024 Push into an empty channel with out_ready high SHALL NOT pop in the same cycle (no bypass).
REQ-025 sel_err SHALL be registered: high in cycle N+1 for one cycle after an accepted push with in_sel >= NUM_CH; non-accepted out-of-range words SHALL NOT pulse it.
REQ-026 No output SHALL be inferred as a latch; every output SHALL be defined for every select value.

Reset
REQ-027 On rst assertion, all counts and pointers SHALL clear asynchronously: out_valid = 0, out_data = 0, sel_err = 0, in_ready = 1.
REQ-028 Reset mid-operation SHALL discard all buffered words; none SHALL appear after release.
REQ-029 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 A shared package demux_router_pkg SHALL hold the channel-index typedef and the DEFAULT_CH and DEPTH defaults.
REQ-031 The per-channel buffer SHALL be one sub-module, demux_router_fifo (parameters DATA_WIDTH, DEPTH), instantiated NUM_CH times by a generate loop.
REQ-032 Select decoding, in_ready muxing and sel_err SHALL live in the top module.

Verification
REQ-033 After reset, push 8'hA5 with in_sel=1 and out_ready=0 -> cycle+1 out_valid=3'b010, channel 1 out_data=8'hA5, channels 0/2 out_data=0.
REQ-034 Push 8'h11, then 8'h22 to channel 2 with out_ready[2]=0 -> in_ready low for sel=2 next cycle, high for sel=0; raise out_ready[2] -> 8'h11 then 8'h22 delivered in order.
REQ-035 Push 8'h3C with in_sel=3 (NUM_CH=3) -> word delivered on DEFAULT_CH=0; sel_err=1 for exactly one cycle.
REQ-036 Hold channel 0 full (DEPTH=2), push with in_sel=0 and out_ready[0]=1 -> in_ready=0 that cycle, word not taken; the following cycle the push is accepted.
REQ-037 Stream alternating sel 0/1 at full rate, all out_ready=1 -> one word per cycle, count per channel never exceeds 1, no loss.
REQ-038 Fill two channels, assert rst for one cycle mid-stream -> out_valid=0 immediately (asynchronous), nothing delivered after release, next push seen at cycle+1.
